// File: rtl/keypad_scanner.sv
// keypad_scanner: column-strobed matrix keypad scanner with frame-level
// debounce, key-code mapping and a single-entry valid/ready event register.
// Optional auto-repeat while a key is held: define KEYPAD_REPEAT_EN.
module keypad_scanner #(
    parameter int unsigned ROWS     = 4,
    parameter int unsigned COLS     = 4,
    parameter int unsigned SCAN_DIV = 1000,
    parameter int unsigned DEBOUNCE = 4
) (
    input  logic            clk,
    input  logic            rst,
    output logic [COLS-1:0] col_drive,
    input  logic [ROWS-1:0] row_in,
    output logic            key_valid,
    input  logic            key_ready,
    output logic [3:0]      key,
    output logic            is_op,
    output logic            is_eq,
    output logic [2:0]      key_row,
    output logic [2:0]      key_col,
    output logic            overflow
);

    localparam int unsigned DIV_W  = $clog2(SCAN_DIV);
    localparam int unsigned IDX_W  = 3;
    localparam int unsigned CNT_W  = 4;
    localparam int unsigned CNTI_W = CNT_W + 1;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        PRESS_DB   = 2'd1,
        HELD       = 2'd2,
        RELEASE_DB = 2'd3
    } state_t;

    logic [ROWS-1:0]   sync1;
    logic [ROWS-1:0]   sync2;
    logic [DIV_W-1:0]  div_cnt;
    logic [IDX_W-1:0]  col_idx;
    logic [1:0]        acc_cnt;
    logic [IDX_W-1:0]  acc_row;
    logic [IDX_W-1:0]  acc_col;
    state_t            state;
    logic [CNT_W-1:0]  count;
    logic [IDX_W-1:0]  cand_row;
    logic [IDX_W-1:0]  cand_col;

    logic              slot_end_c;
    logic              frame_end_c;
    logic [1:0]        cur_cnt_c;
    logic [2:0]        sum_c;
    logic [1:0]        tot_c;
    logic [IDX_W-1:0]  frm_row_c;
    logic [IDX_W-1:0]  frm_col_c;
    logic              is_none_c;
    logic              is_single_c;
    logic              same_c;
    logic [CNTI_W-1:0] cnt_inc_c;
    logic              deb_hit_c;
    logic              rep_fire_c;
    logic              accept_c;
    logic [3:0]        ev_key_c;
    logic              ev_op_c;
    logic              ev_eq_c;

    // Number of set bits, saturating at 2 (only none/one/many matters).
    function automatic logic [1:0] sat_pop(input logic [ROWS-1:0] v);
        logic [1:0] n;
        n = 2'd0;
        for (int i = 0; i < int'(ROWS); i++) begin
            if (v[i] && (n != 2'd2)) n = n + 2'd1;
        end
        return n;
    endfunction

    // Index of the lowest set bit (0 when none set).
    function automatic logic [IDX_W-1:0] low_idx(input logic [ROWS-1:0] v);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int i = int'(ROWS) - 1; i >= 0; i--) begin
            if (v[i]) idx = IDX_W'(i);
        end
        return idx;
    endfunction

    // Calculator layout for the top-left 4x4; anything outside maps to 0.
    function automatic logic [3:0] map_key(input logic [IDX_W-1:0] r,
                                           input logic [IDX_W-1:0] c);
        logic [3:0] k;
        k = 4'd0;
        if (!r[2] && !c[2]) begin
            case ({r[1:0], c[1:0]})
                4'h0: k = 4'd1;
                4'h1: k = 4'd2;
                4'h2: k = 4'd3;
                4'h3: k = 4'd10;
                4'h4: k = 4'd4;
                4'h5: k = 4'd5;
                4'h6: k = 4'd6;
                4'h7: k = 4'd11;
                4'h8: k = 4'd7;
                4'h9: k = 4'd8;
                4'hA: k = 4'd9;
                4'hB: k = 4'd12;
                4'hC: k = 4'd14;
                4'hD: k = 4'd0;
                4'hE: k = 4'd15;
                default: k = 4'd13;
            endcase
        end
        return k;
    endfunction

    // Two-flop synchroniser for the asynchronous row inputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= row_in;
            sync2 <= sync1;
        end
    end

    // Column strobe: SCAN_DIV clocks per column, wrapping after the last.
    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt   <= '0;
            col_idx   <= '0;
            col_drive <= COLS'(1);
        end else if (slot_end_c) begin
            div_cnt <= '0;
            if (col_idx == IDX_W'(COLS - 1)) begin
                col_idx   <= '0;
                col_drive <= COLS'(1);
            end else begin
                col_idx   <= col_idx + IDX_W'(1);
                col_drive <= col_drive << 1;
            end
        end else begin
            div_cnt <= div_cnt + DIV_W'(1);
        end
    end

    // Frame classification from the accumulated and current column samples.
    always_comb begin
        slot_end_c  = (div_cnt == DIV_W'(SCAN_DIV - 1));
        frame_end_c = slot_end_c && (col_idx == IDX_W'(COLS - 1));
        cur_cnt_c   = sat_pop(sync2);
        sum_c       = {1'b0, acc_cnt} + {1'b0, cur_cnt_c};
        tot_c       = (sum_c >= 3'd2) ? 2'd2 : sum_c[1:0];
        frm_row_c   = (acc_cnt == 2'd0) ? low_idx(sync2) : acc_row;
        frm_col_c   = (acc_cnt == 2'd0) ? col_idx : acc_col;
        is_none_c   = frame_end_c && (tot_c == 2'd0);
        is_single_c = frame_end_c && (tot_c == 2'd1);
        same_c      = (frm_row_c == cand_row) && (frm_col_c == cand_col);
        cnt_inc_c   = {1'b0, count} + CNTI_W'(1);
        deb_hit_c   = (cnt_inc_c == CNTI_W'(DEBOUNCE));
        ev_key_c    = map_key(frm_row_c, frm_col_c);
        ev_op_c     = (ev_key_c >= 4'd10) && (ev_key_c <= 4'd13);
        ev_eq_c     = (ev_key_c == 4'd15);
    end

    // Per-frame accumulator: hit count (saturating) and first hit position.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_cnt <= '0;
            acc_row <= '0;
            acc_col <= '0;
        end else if (frame_end_c) begin
            acc_cnt <= '0;
        end else if (slot_end_c) begin
            acc_cnt <= tot_c;
            acc_row <= frm_row_c;
            acc_col <= frm_col_c;
        end
    end

`ifdef KEYPAD_REPEAT_EN
    logic [4:0] rep_cnt;
    logic       rep_first;
    logic [4:0] rep_inc_c;

    always_comb begin
        rep_inc_c  = rep_cnt + 5'd1;
        rep_fire_c = (state == HELD) && is_single_c && same_c &&
                     (rep_first ? (rep_inc_c == 5'd16) : (rep_inc_c == 5'd4));
    end

    // Repeat timer: first re-emit 16 held frames after acceptance, then every 4.
    always_ff @(posedge clk) begin
        if (rst) begin
            rep_cnt   <= '0;
            rep_first <= 1'b0;
        end else if (accept_c && (state != HELD)) begin
            rep_cnt   <= '0;
            rep_first <= 1'b1;
        end else if ((state == HELD) && is_single_c && same_c) begin
            if (rep_fire_c) begin
                rep_cnt   <= '0;
                rep_first <= 1'b0;
            end else begin
                rep_cnt <= rep_inc_c;
            end
        end
    end
`else
    assign rep_fire_c = 1'b0;
`endif

    // A press is accepted on the frame its debounce count reaches DEBOUNCE.
    always_comb begin
        accept_c = 1'b0;
        case (state)
            IDLE:     accept_c = is_single_c && (DEBOUNCE == 1);
            PRESS_DB: accept_c = is_single_c && same_c && deb_hit_c;
            HELD:     accept_c = rep_fire_c;
            default:  accept_c = 1'b0;
        endcase
    end

    // Debounce state machine, advanced once per completed frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            count    <= '0;
            cand_row <= '0;
            cand_col <= '0;
        end else if (frame_end_c) begin
            case (state)
                IDLE: begin
                    if (is_single_c) begin
                        cand_row <= frm_row_c;
                        cand_col <= frm_col_c;
                        if (DEBOUNCE == 1) begin
                            state <= HELD;
                            count <= '0;
                        end else begin
                            state <= PRESS_DB;
                            count <= CNT_W'(1);
                        end
                    end
                end
                PRESS_DB: begin
                    if (is_single_c && same_c) begin
                        if (deb_hit_c) begin
                            state <= HELD;
                            count <= '0;
                        end else begin
                            count <= cnt_inc_c[CNT_W-1:0];
                        end
                    end else if (is_single_c) begin
                        cand_row <= frm_row_c;
                        cand_col <= frm_col_c;
                        count    <= CNT_W'(1);
                    end else begin
                        state <= IDLE;
                        count <= '0;
                    end
                end
                HELD: begin
                    if (is_none_c) begin
                        if (DEBOUNCE == 1) begin
                            state <= IDLE;
                            count <= '0;
                        end else begin
                            state <= RELEASE_DB;
                            count <= CNT_W'(1);
                        end
                    end
                end
                default: begin
                    if (is_none_c) begin
                        if (deb_hit_c) begin
                            state <= IDLE;
                            count <= '0;
                        end else begin
                            count <= cnt_inc_c[CNT_W-1:0];
                        end
                    end else begin
                        state <= HELD;
                        count <= '0;
                    end
                end
            endcase
        end
    end

    // Event register: load when free or being consumed, else drop and flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            key_valid <= 1'b0;
            key       <= '0;
            is_op     <= 1'b0;
            is_eq     <= 1'b0;
            key_row   <= '0;
            key_col   <= '0;
            overflow  <= 1'b0;
        end else if (accept_c) begin
            if (!key_valid || key_ready) begin
                key_valid <= 1'b1;
                key       <= ev_key_c;
                is_op     <= ev_op_c;
                is_eq     <= ev_eq_c;
                key_row   <= frm_row_c;
                key_col   <= frm_col_c;
            end else begin
                overflow <= 1'b1;
            end
        end else if (key_valid && key_ready) begin
            key_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_keypad_scanner.sv
// Testbench for keypad_scanner: keypad matrix model, frame-level reference
// model of the debounce rules, and a scoreboard checked on each handshake.
module tb_keypad_scanner;

    localparam int ROWS     = 4;
    localparam int COLS     = 4;
    localparam int SCAN_DIV = 4;
    localparam int DEB      = 4;
    localparam int FRAME    = ROWS * 0 + COLS * SCAN_DIV;

    typedef struct packed {
        logic [3:0]  key;
        logic        op;
        logic        eq;
        logic [2:0]  row;
        logic [2:0]  col;
        logic [31:0] cyc;
    } exp_t;

    logic            clk;
    logic            rst;
    logic [COLS-1:0] col_drive;
    logic [ROWS-1:0] row_in;
    logic            key_valid;
    logic            key_ready;
    logic [3:0]      key;
    logic            is_op;
    logic            is_eq;
    logic [2:0]      key_row;
    logic [2:0]      key_col;
    logic            overflow;

    logic [COLS-1:0] pm [ROWS];
    logic [31:0]     cyc;
    exp_t            sb[$];
    int              vectors;
    int              miscompares;

    int key_tbl [16] = '{1, 2, 3, 10, 4, 5, 6, 11, 7, 8, 9, 12, 14, 0, 15, 13};

    // reference model state
    int run, none_run, cand_r, cand_c, rep_n, frame_idx;
    bit held, rep_first, exp_ovf;

    keypad_scanner #(
        .ROWS(ROWS), .COLS(COLS), .SCAN_DIV(SCAN_DIV), .DEBOUNCE(DEB)
    ) dut (
        .clk(clk), .rst(rst), .col_drive(col_drive), .row_in(row_in),
        .key_valid(key_valid), .key_ready(key_ready), .key(key),
        .is_op(is_op), .is_eq(is_eq), .key_row(key_row), .key_col(key_col),
        .overflow(overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rst) cyc <= 32'd0;
        else     cyc <= cyc + 32'd1;
    end

    // Passive matrix: a row senses high when a pressed key sits in the driven column.
    always_comb begin
        row_in = '0;
        for (int r = 0; r < ROWS; r++) row_in[r] = |(pm[r] & col_drive);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic set_none();
        for (int r = 0; r < ROWS; r++) pm[r] = '0;
    endtask

    task automatic set_key(input int r, input int c);
        set_none();
        pm[r][c] = 1'b1;
    endtask

    task automatic model_reset();
        run = 0; none_run = 0; cand_r = 0; cand_c = 0; rep_n = 0;
        frame_idx = 0; held = 0; rep_first = 0; exp_ovf = 0;
    endtask

    // One frame of the reference model, computed from the pressed-key set.
    task automatic model_frame();
        int n, pr, pc, k;
        bit fire, same;
        exp_t e;
        n = 0; pr = 0; pc = 0; fire = 0;
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                if (pm[r][c]) begin
                    if (n == 0) begin pr = r; pc = c; end
                    n++;
                end
        same = (n == 1) && (pr == cand_r) && (pc == cand_c);
        if (!held) begin
            if (same && run > 0) run++;
            else if (n == 1) begin cand_r = pr; cand_c = pc; run = 1; end
            else run = 0;
            if (run == DEB) begin
                fire = 1; held = 1; run = 0; none_run = 0; rep_n = 0; rep_first = 1;
            end
        end else begin
`ifdef KEYPAD_REPEAT_EN
            if (same && none_run == 0) begin
                rep_n++;
                if (rep_n == (rep_first ? 16 : 4)) begin
                    fire = 1; rep_n = 0; rep_first = 0;
                end
            end
`endif
            if (n == 0) begin
                none_run++;
                if (none_run == DEB) begin held = 0; none_run = 0; end
            end else begin
                none_run = 0;
            end
        end
        frame_idx++;
        if (fire) begin
            k = key_tbl[cand_r * 4 + cand_c];
            e.key = 4'(k);
            e.op  = (k >= 10 && k <= 13);
            e.eq  = (k == 15);
            e.row = 3'(cand_r);
            e.col = 3'(cand_c);
            e.cyc = 32'(frame_idx * FRAME);
            if (sb.size() > 0 && !key_ready) exp_ovf = 1;
            else sb.push_back(e);
        end
    endtask

    task automatic run_frames(input int n);
        for (int i = 0; i < n; i++) begin
            model_frame();
            repeat (FRAME) @(negedge clk);
        end
    endtask

    task automatic do_reset();
        check("events_outstanding_before_reset", 32'(sb.size()), 32'd0);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_col_drive", 32'(col_drive), 32'd1);
        check("rst_key_valid", 32'(key_valid), 32'd0);
        check("rst_key",       32'(key),       32'd0);
        check("rst_is_op",     32'(is_op),     32'd0);
        check("rst_is_eq",     32'(is_eq),     32'd0);
        check("rst_key_row",   32'(key_row),   32'd0);
        check("rst_key_col",   32'(key_col),   32'd0);
        check("rst_overflow",  32'(overflow),  32'd0);
        rst = 1'b0;
        model_reset();
    endtask

    // Scoreboard monitor: timing on each rising key_valid, payload on each handshake.
    task automatic monitor();
        logic prev_v;
        exp_t e;
        prev_v = 1'b0;
        forever begin
            @(negedge clk);
            #1;
            if (rst) begin
                prev_v = 1'b0;
            end else begin
                if (key_valid && !prev_v) begin
                    if (sb.size() == 0) begin
                        vectors++; miscompares++;
                        $display("FAIL unexpected_event: key_valid rose with key=%0d at cycle %0d, none expected", key, cyc);
                    end else begin
                        check("event_cycle", cyc, sb[0].cyc);
                    end
                end
                if (key_valid && key_ready) begin
                    if (sb.size() == 0) begin
                        vectors++; miscompares++;
                        $display("FAIL unexpected_handshake: key=%0d at cycle %0d, none expected", key, cyc);
                    end else begin
                        e = sb.pop_front();
                        check("ev_key", 32'(key),     32'(e.key));
                        check("ev_is_op", 32'(is_op), 32'(e.op));
                        check("ev_is_eq", 32'(is_eq), 32'(e.eq));
                        check("ev_row", 32'(key_row), 32'(e.row));
                        check("ev_col", 32'(key_col), 32'(e.col));
                    end
                end
                prev_v = key_valid;
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int sel, len, r2, c2;
        vectors = 0;
        miscompares = 0;
        rst = 1'b1;
        key_ready = 1'b1;
        set_none();
        model_reset();
        fork
            monitor();
        join_none
        repeat (2) @(negedge clk);
        do_reset();

        // single operator key held 5 frames
        set_key(0, 3); run_frames(5);
        set_none();    run_frames(DEB);

        // short press rejected, full press accepted
        set_key(3, 2); run_frames(3);
        set_none();    run_frames(2);
        set_key(3, 2); run_frames(4);
        set_none();    run_frames(DEB);

        // two keys together: never accepted
        set_none(); pm[1][1] = 1'b1; pm[2][0] = 1'b1; run_frames(10);

        // stalled consumer: second event dropped, overflow set
        key_ready = 1'b0;
        set_key(0, 0); run_frames(4);
        set_none();    run_frames(DEB);
        set_key(1, 0); run_frames(4);
        check("ovf_key_valid", 32'(key_valid), 32'd1);
        check("ovf_key_kept",  32'(key),       32'd1);
        check("ovf_flag",      32'(overflow),  32'd1);
        check("ovf_flag_model", 32'(overflow), 32'(exp_ovf));
        key_ready = 1'b1;
        @(negedge clk);
        check("valid_falls_after_handshake", 32'(key_valid), 32'd0);
        set_none(); run_frames(DEB);

        // reset in the middle of press debounce
        set_key(0, 1); run_frames(3);
        repeat (FRAME / 2) @(negedge clk);
        do_reset();
        run_frames(4);
        set_none(); run_frames(DEB);

        // randomized keypad activity
        for (int i = 0; i < 120; i++) begin
            sel = int'($urandom_range(0, 9));
            len = int'($urandom_range(1, 6));
            if (sel <= 2) begin
                set_none();
            end else if (sel <= 7) begin
                set_key(int'($urandom_range(0, ROWS - 1)), int'($urandom_range(0, COLS - 1)));
            end else begin
                set_key(int'($urandom_range(0, ROWS - 1)), int'($urandom_range(0, COLS - 1)));
                r2 = int'($urandom_range(0, ROWS - 1));
                c2 = int'($urandom_range(0, COLS - 1));
                pm[r2][c2] = 1'b1;
            end
            run_frames(len);
        end
        set_none(); run_frames(DEB);

`ifdef KEYPAD_REPEAT_EN
        // long hold with auto-repeat
        set_key(2, 1); run_frames(30);
        set_none();    run_frames(DEB);
`endif

        run_frames(2);
        check("events_outstanding_at_end", 32'(sb.size()), 32'd0);
        check("final_overflow", 32'(overflow), 32'(exp_ovf));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/keypad_scanner.md
KEYPAD_SCANNER -- requirements
Module: keypad_scanner

Interface
REQ-001 SHALL have parameter ROWS, default 4, meaning number of keypad rows (1..8).
REQ-002 SHALL have parameter COLS, default 4, meaning number of keypad columns (1..8).
REQ-003 SHALL have parameter SCAN_DIV, default 1000, meaning clocks each column is driven (>=4).
REQ-004 SHALL have parameter DEBOUNCE, default 4, meaning consecutive identical frames needed to accept a press or release (1..15).
REQ-005 SHALL have port clk  input  1  the single clock; all logic on its rising edge.
REQ-006 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-007 SHALL have port col_drive  output  COLS  one-hot column strobe, active-high.
REQ-008 SHALL have port row_in  input  ROWS  raw row sense, active-high, asynchronous to clk.
REQ-009 SHALL have port key_valid  output  1  key event pending.
REQ-010 SHALL have port key_ready  input  1  consumer accepts the event.
REQ-011 SHALL have port key  output  4  key code of the event.
REQ-012 SHALL have port is_op  output  1  event is an operator (+ - * /).
REQ-013 SHALL have port is_eq  output  1  event is '='.
REQ-014 SHALL have port key_row  output  3  row index of the event.
REQ-015 SHALL have port key_col  output  3  column index of the event.
REQ-016 SHALL have port overflow  output  1  sticky: an event was dropped.

Function
REQ-017 SHALL pass row_in through a 2-flop synchroniser before any use.
REQ-018 SHALL drive col_drive one-hot, starting at column 0, for SCAN_DIV cycles per column, advancing 0..COLS-1 and wrapping to 0; one full pass is a frame.
REQ-019 SHALL sample the synchronised rows on the last cycle of each column slot.
REQ-020 SHALL classify each frame as NONE (no row set), SINGLE (exactly one row in exactly one column) or MULTI (anything else).
REQ-021 SHALL run a state machine IDLE -> PRESS_DB -> HELD -> RELEASE_DB -> IDLE.
REQ-022 IDLE: SINGLE frame latches candidate (row, col), count=1, goes PRESS_DB (or accepts immediately when DEBOUNCE=1).
REQ-023 PRESS_DB: SINGLE with same candidate increments count; on reaching DEBOUNCE, emit event and go HELD; different SINGLE re-latches candidate with count=1; NONE or MULTI returns to IDLE.
REQ-024 HELD: NONE frame goes RELEASE_DB with count=1; SINGLE same or MULTI stays HELD.
REQ-025 RELEASE_DB: NONE increments count, reaching DEBOUNCE returns IDLE; any key returns HELD.
REQ-026 SHALL map (r,c) for r<4, c<4 row-major: row0 1,2,3,+(10); row1 4,5,6,-(11); row2 7,8,9,*(12); row3 Clear(14),0,=(15),/(13); is_op for codes 10-13, is_eq for 15 only.
REQ-027 SHALL map positions with r>=4 or c>=4 to key=0, is_op=0, is_eq=0, with true key_row/key_col.
REQ-028 SHALL register the event: key_valid rises the cycle after the accepting sample; key/flags/row/col stable while key_valid=1.
REQ-029 SHALL hold key_valid until a cycle with key_valid=1 and key_ready=1; key_valid falls the next cycle.
REQ-030 SHALL, if a new event is generated while key_valid=1 and no handshake that cycle, drop the new event, keep the old, and set overflow.
REQ-031 SHALL accept a handshake and a new event in the same cycle by loading the new event with key_valid kept high.

Reset
REQ-032 rst SHALL force: col_drive=1 (column 0), scan counter 0, synchronisers 0, state IDLE, count 0, key_valid=0, key=0, is_op=0, is_eq=0, key_row=0, key_col=0, overflow=0.
REQ-033 rst mid-scan or mid-debounce SHALL discard all in-progress state; no event is emitted for a press in progress at reset.

Configuration
REQ-034 Macro KEYPAD_REPEAT_EN SHALL enable auto-repeat: in HELD with a SINGLE key, re-emit the same event after 16 frames, then every 4 frames, subject to REQ-030.
REQ-035 Without KEYPAD_REPEAT_EN, exactly one event SHALL be emitted per accepted press.

Verification
REQ-036 Defaults, SCAN_DIV=4: hold row 0 while col 3 driven for 5 frames, key_ready=1 -> one event key=10, is_op=1, key_row=0, key_col=3.
REQ-037 Press (3,2) for 3 frames then release -> no event; press 4 frames -> key=15, is_eq=1.
REQ-038 Keys (1,1) and (2,0) held together for 10 frames -> no event, state stays IDLE.
REQ-039 key_ready=0, accept (0,0) then release/press (1,0) -> key_valid=1 with key=1, overflow=1; raise key_ready -> key_valid falls next cycle.
REQ-040 Assert rst during PRESS_DB at count 3 -> all outputs at reset values, no event until 4 fresh frames.
REQ-041 With KEYPAD_REPEAT_EN, hold (2,1) for 30 frames, key_ready=1 -> events key=8 at frame 4, 20, 24, 28.
